// File: rtl/qs_srt_decoder_if.sv
// rtl/qs_srt_decoder_if.sv - shared decode types plus fetch/ucode handshake interface.
package qs_srt_pkg;
  typedef logic [15:0] inst_t;
  typedef logic [7:0]  pc_t;
  typedef logic [2:0]  reg_t;

  localparam reg_t BLINK = 3'd7;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_JCC   = 4'h1,
    OP_PP    = 4'h2,
    OP_MEM   = 4'h4,
    OP_MOV   = 4'h6,
    OP_ARITH = 4'h7,
    OP_CRET  = 4'hC,
    OP_CNTRL = 4'hF
  } opcode_e;

  typedef struct packed {
    logic       is_jump;
    logic       is_push;
    logic       is_pop;
    logic       is_load;
    logic       is_store;
    logic       is_call;
    logic       is_ret;
    logic       is_done;
    logic       is_await;
    logic [1:0] cc;
    logic [7:0] target;
    logic       dst_en;
    reg_t       dst;
    logic       dst_is_blink;
    logic       src0_en;
    reg_t       src0;
    logic       src0_is_zero;
    logic       src1_en;
    reg_t       src1;
    logic       inv_src1;
    logic       cin;
    logic       has_imm;
    reg_t       imm;
    logic       has_special;
    reg_t       special;
    logic       flag_en;
    logic       invalid_inst;
  } ucode_t;
endpackage

interface qs_srt_decoder_if;
  import qs_srt_pkg::*;

  logic   fetch_vld;
  inst_t  fetch_inst;
  pc_t    fetch_pc;
  logic   fetch_rdy;
  logic   ucode_vld_r;
  ucode_t ucode_r;
  pc_t    ucode_pc_r;
  logic   ucode_rdy;

  modport master (
    output fetch_vld, fetch_inst, fetch_pc, ucode_rdy,
    input  fetch_rdy, ucode_vld_r, ucode_r, ucode_pc_r
  );

  modport slave (
    input  fetch_vld, fetch_inst, fetch_pc, ucode_rdy,
    output fetch_rdy, ucode_vld_r, ucode_r, ucode_pc_r
  );
endinterface

// File: rtl/qs_srt_decoder.sv
// rtl/qs_srt_decoder.sv - microsequencer decode stage with one registered ucode slot.
// Optional pop->use interlock and bubble counter: QS_SRT_DECODER_POP_INTERLOCK_EN.
module qs_srt_decoder
  import qs_srt_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  qs_srt_decoder_if.slave        io,
  input  logic                   flush,
  output logic                   invalid_err_r,
  output logic [STALL_CNT_W-1:0] stall_cnt_r
);

  inst_t  w;
  reg_t   r_fld;
  reg_t   s_fld;
  reg_t   l_fld;
  logic   hi_bit;
  ucode_t dec_u;

  assign w      = io.fetch_inst;
  assign hi_bit = w[11];
  assign r_fld  = w[10:8];
  assign s_fld  = w[6:4];
  assign l_fld  = w[2:0];

  always_comb begin
    dec_u = '0;
    case (w[15:12])
      OP_NOP: ;
      OP_JCC: begin
        dec_u.is_jump = 1'b1;
        dec_u.cc      = w[9:8];
        dec_u.target  = w[7:0];
      end
      OP_PP: begin
        if (hi_bit) begin
          dec_u.is_pop = 1'b1;
          dec_u.dst_en = 1'b1;
          dec_u.dst    = r_fld;
        end else begin
          dec_u.is_push = 1'b1;
          dec_u.src1_en = 1'b1;
          dec_u.src1    = l_fld;
        end
      end
      OP_MEM: begin
        dec_u.src1_en = 1'b1;
        dec_u.src1    = l_fld;
        if (hi_bit) begin
          dec_u.is_store = 1'b1;
          dec_u.src0_en  = 1'b1;
          dec_u.src0     = s_fld;
        end else begin
          dec_u.is_load = 1'b1;
          dec_u.dst_en  = 1'b1;
          dec_u.dst     = r_fld;
        end
      end
      OP_MOV: begin
        dec_u.dst_en       = 1'b1;
        dec_u.dst          = r_fld;
        dec_u.src0_is_zero = 1'b1;
        if (hi_bit) begin
          dec_u.has_special = 1'b1;
          dec_u.special     = l_fld;
        end else if (w[3]) begin
          dec_u.has_imm = 1'b1;
          dec_u.imm     = l_fld;
        end else begin
          dec_u.src1_en = 1'b1;
          dec_u.src1    = l_fld;
        end
      end
      OP_ARITH: begin
        // Subtract is add with inverted src1 and carry-in set.
        dec_u.dst_en   = w[7];
        dec_u.dst      = r_fld;
        dec_u.src0_en  = 1'b1;
        dec_u.src0     = s_fld;
        dec_u.flag_en  = 1'b1;
        dec_u.inv_src1 = hi_bit;
        dec_u.cin      = hi_bit;
        if (w[3]) begin
          dec_u.has_imm = 1'b1;
          dec_u.imm     = l_fld;
        end else begin
          dec_u.src1_en = 1'b1;
          dec_u.src1    = l_fld;
        end
      end
      OP_CRET: begin
        if (hi_bit) begin
          dec_u.is_ret  = 1'b1;
          dec_u.src0_en = 1'b1;
          dec_u.src0    = BLINK;
        end else begin
          dec_u.is_call      = 1'b1;
          dec_u.target       = w[7:0];
          dec_u.dst_en       = 1'b1;
          dec_u.dst          = BLINK;
          dec_u.dst_is_blink = 1'b1;
        end
      end
      OP_CNTRL: begin
        dec_u.is_done  = hi_bit;
        dec_u.is_await = ~hi_bit;
      end
      default: dec_u.invalid_inst = 1'b1;
    endcase
  end

  logic   ucode_vld_q, ucode_vld_d;
  ucode_t ucode_q, ucode_d;
  pc_t    ucode_pc_q, ucode_pc_d;
  logic   invalid_err_q, invalid_err_d;
  logic   adv;
  logic   hazard;
  logic   accept;

  assign adv          = ~ucode_vld_q | io.ucode_rdy;
  assign io.fetch_rdy = adv & ~flush & ~hazard;
  assign accept       = io.fetch_vld & io.fetch_rdy;

`ifdef QS_SRT_DECODER_POP_INTERLOCK_EN
  logic                   pop_pend_q, pop_pend_d;
  reg_t                   pop_dst_q, pop_dst_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign hazard = pop_pend_q & io.fetch_vld &
                  ((dec_u.src0_en & (dec_u.src0 == pop_dst_q)) |
                   (dec_u.src1_en & (dec_u.src1 == pop_dst_q)));

  // Any cycle the slot advances without an accept is a bubble, which satisfies the pop gap.
  always_comb begin
    pop_pend_d  = pop_pend_q;
    pop_dst_d   = pop_dst_q;
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      pop_pend_d = 1'b0;
    end else if (accept) begin
      pop_pend_d = dec_u.is_pop;
      pop_dst_d  = dec_u.dst;
    end else if (adv) begin
      pop_pend_d = 1'b0;
      if (hazard && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pop_pend_q  <= 1'b0;
      pop_dst_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      pop_pend_q  <= pop_pend_d;
      pop_dst_q   <= pop_dst_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_r = stall_cnt_q;
`else
  assign hazard      = 1'b0;
  assign stall_cnt_r = '0;
`endif

  always_comb begin
    ucode_vld_d   = ucode_vld_q;
    ucode_d       = ucode_q;
    ucode_pc_d    = ucode_pc_q;
    invalid_err_d = invalid_err_q;
    if (flush) begin
      ucode_vld_d = 1'b0;
    end else if (accept) begin
      ucode_vld_d   = 1'b1;
      ucode_d       = dec_u;
      ucode_pc_d    = io.fetch_pc;
      invalid_err_d = invalid_err_q | dec_u.invalid_inst;
    end else if (adv) begin
      ucode_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ucode_vld_q   <= 1'b0;
      ucode_q       <= '0;
      ucode_pc_q    <= '0;
      invalid_err_q <= 1'b0;
    end else begin
      ucode_vld_q   <= ucode_vld_d;
      ucode_q       <= ucode_d;
      ucode_pc_q    <= ucode_pc_d;
      invalid_err_q <= invalid_err_d;
    end
  end

  assign io.ucode_vld_r = ucode_vld_q;
  assign io.ucode_r     = ucode_q;
  assign io.ucode_pc_r  = ucode_pc_q;
  assign invalid_err_r  = invalid_err_q;

endmodule
